// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage multiply/divide unit with the architectural HI/LO registers.
// MULT/MULTU take one extra cycle. DIV/DIVU use a restoring divider that takes
// DATA_WIDTH iteration cycles, and stall_req holds IF/ID/EX for that time.
// MTHI/MTLO write HI/LO. MFHI/MFLO read them through read_data.
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-low reset
//   flush            synchronous abort of any in-flight operation
//   op_valid, funct  valid instruction in EX and its 6-bit funct code
//   operand_1/2      rs / rt values
//   stall_req        combinational pipeline hold request
//   read_data        combinational HI/LO read for MFHI/MFLO, else 0
//   hi, lo           architectural HI/LO registers
module ex_muldiv #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  op_valid,
  input  logic [5:0]            funct,
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  output logic                  stall_req,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MUL     = 2'd1;
  localparam logic [1:0] S_DIV_RUN = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     a_q, a_d;          // raw operand_1 (multiplicand / div-by-zero result)
  logic [W-1:0]     b_q, b_d;          // multiplier, or divisor magnitude
  logic             sgn_q, sgn_d;
  logic             dz_q, dz_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;      // dividend magnitude shifts out, quotient shifts in
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;

  logic             is_mul, is_div, is_sgn;
  logic [2*W-1:0]   a_ext, b_ext, prod;
  logic [W:0]       trial, diff;
  logic             ge;
  logic [W-1:0]     rem_step, quo_step;

  // Funct decode
  always_comb begin
    is_mul = (funct == F_MULT) || (funct == F_MULTU);
    is_div = (funct == F_DIV)  || (funct == F_DIVU);
    is_sgn = (funct == F_MULT) || (funct == F_DIV);
  end

  // Full-width product: low 2W bits of an extended multiply are correct for both signednesses
  always_comb begin
    a_ext = sgn_q ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
    b_ext = sgn_q ? {{W{b_q[W-1]}}, b_q} : {{W{1'b0}}, b_q};
    prod  = a_ext * b_ext;
  end

  // One restoring shift-subtract step; diff[W] set means the trial was below the divisor
  always_comb begin
    trial    = {rem_q, quo_q[W-1]};
    diff     = trial - {1'b0, b_q};
    ge       = ~diff[W];
    rem_step = ge ? diff[W-1:0] : trial[W-1:0];
    quo_step = {quo_q[W-2:0], ge};
  end

  // Next-state, datapath and stall logic
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    dz_d      = dz_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stall_req = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_valid) begin
            if (is_mul) begin
              stall_req = 1'b1;
              state_d   = S_MUL;
              a_d       = operand_1;
              b_d       = operand_2;
              sgn_d     = is_sgn;
            end else if (is_div) begin
              stall_req = 1'b1;
              state_d   = S_DIV_RUN;
              a_d       = operand_1;
              b_d       = (is_sgn && operand_2[W-1]) ? W'(-operand_2) : operand_2;
              quo_d     = (is_sgn && operand_1[W-1]) ? W'(-operand_1) : operand_1;
              rem_d     = '0;
              cnt_d     = '0;
              sgn_d     = is_sgn;
              dz_d      = (operand_2 == '0);
              qneg_d    = is_sgn && (operand_1[W-1] ^ operand_2[W-1]);
              rneg_d    = is_sgn && operand_1[W-1];
            end else if (funct == F_MTHI) begin
              hi_d = operand_1;
            end else if (funct == F_MTLO) begin
              lo_d = operand_1;
            end
          end
        end
        S_MUL: begin
          stall_req    = 1'b1;
          state_d      = S_DONE;
          {hi_d, lo_d} = prod;
        end
        S_DIV_RUN: begin
          stall_req = 1'b1;
          rem_d     = rem_step;
          quo_d     = quo_step;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(W - 1)) begin
            state_d = S_DONE;
            if (dz_q) begin
              lo_d = '1;
              hi_d = a_q;
            end else begin
              lo_d = qneg_q ? W'(-quo_step) : quo_step;
              hi_d = rneg_q ? W'(-rem_step) : rem_step;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    // Never request a hold while reset is asserted
    if (!rst) begin
      stall_req = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      dz_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      dz_q    <= dz_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // HI/LO read port; no same-cycle forwarding from MTHI/MTLO
  always_comb begin
    read_data = '0;
    if (op_valid && (funct == F_MFHI)) begin
      read_data = hi_q;
    end else if (op_valid && (funct == F_MFLO)) begin
      read_data = lo_q;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Testbench for ex_muldiv: directed scenarios plus randomized instruction mix
// checked against a plain-arithmetic HI/LO reference model.
module tb_ex_muldiv;

  localparam int unsigned W = 32;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         op_valid;
  logic [5:0]   funct;
  logic [W-1:0] operand_1;
  logic [W-1:0] operand_2;
  logic         stall_req;
  logic [W-1:0] read_data;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int passed = 0;
  int total  = 0;

  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  always #5 clk = ~clk;

  ex_muldiv #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .op_valid  (op_valid),
    .funct     (funct),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .stall_req (stall_req),
    .read_data (read_data),
    .hi        (hi),
    .lo        (lo)
  );

  // Reference: full product as {hi,lo}
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint x, y, p;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'b0, a});
      y = longint'({32'b0, b});
    end
    p = x * y;
    return 64'(p);
  endfunction

  // Reference: {remainder, quotient}; divide by zero gives {dividend, all ones}
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint x, y, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'b0, a});
      y = longint'({32'b0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Present an instruction and count stalled cycles; returns in the first non-stalled cycle
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int stalls);
    @(negedge clk);
    funct     = f;
    operand_1 = a;
    operand_2 = b;
    op_valid  = 1'b1;
    flush     = 1'b0;
    stalls    = 0;
    #1;
    while (stall_req === 1'b1 && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    op_valid  = 1'b0;
    funct     = 6'h00;
    flush     = 1'b0;
    operand_1 = '0;
    operand_2 = '0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; op_valid = 1'b0; funct = 6'h00;
    operand_1 = '0; operand_2 = '0;
    repeat (2) @(negedge clk);
    op_valid = 1'b1; funct = F_DIV; operand_1 = 32'd9; operand_2 = 32'd2;
    #1;
    total++; if (hi !== 32'd0) $display("FAIL reset_hi got=%h exp=0", hi); else passed++;
    total++; if (lo !== 32'd0) $display("FAIL reset_lo got=%h exp=0", lo); else passed++;
    total++; if (stall_req !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall_req); else passed++;
    funct = F_MFHI;
    #1;
    total++; if (read_data !== 32'd0) $display("FAIL reset_rdata got=%h exp=0", read_data); else passed++;
    @(negedge clk);
    op_valid = 1'b0;
    rst = 1'b1;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mt_mf();
    int s;
    issue(F_MTHI, 32'h1234, 32'hDEAD, s);
    total++; if (s != 0) $display("FAIL mthi_stall got=%0d exp=0", s); else passed++;
    issue(F_MTLO, 32'h5678, 32'hBEEF, s);
    total++; if (s != 0) $display("FAIL mtlo_stall got=%0d exp=0", s); else passed++;
    issue(F_MFHI, 32'h0, 32'h0, s);
    total++; if (read_data !== 32'h1234) $display("FAIL mfhi got=%h exp=00001234", read_data); else passed++;
    issue(F_MFLO, 32'h0, 32'h0, s);
    total++; if (read_data !== 32'h5678) $display("FAIL mflo got=%h exp=00005678", read_data); else passed++;
    total++; if (s != 0) $display("FAIL mf_stall got=%0d exp=0", s); else passed++;
    m_hi = 32'h1234; m_lo = 32'h5678;
  endtask

  task automatic test_mult();
    int s;
    issue(F_MULT, 32'hFFFF_FFFE, 32'd3, s);
    total++; if (s != 2) $display("FAIL mult_stalls got=%0d exp=2", s); else passed++;
    total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got=%h exp=ffffffff", hi); else passed++;
    total++; if (lo !== 32'hFFFF_FFFA) $display("FAIL mult_lo got=%h exp=fffffffa", lo); else passed++;
    issue(F_MULTU, 32'hFFFF_FFFE, 32'd3, s);
    total++; if (s != 2) $display("FAIL multu_stalls got=%0d exp=2", s); else passed++;
    total++; if (hi !== 32'd2) $display("FAIL multu_hi got=%h exp=00000002", hi); else passed++;
    total++; if (lo !== 32'hFFFF_FFFA) $display("FAIL multu_lo got=%h exp=fffffffa", lo); else passed++;
    m_hi = 32'd2; m_lo = 32'hFFFF_FFFA;
  endtask

  task automatic test_div();
    int s;
    issue(F_DIV, 32'hFFFF_FFF9, 32'd2, s);
    total++; if (s != 33) $display("FAIL div_stalls got=%0d exp=33", s); else passed++;
    total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_lo got=%h exp=fffffffd", lo); else passed++;
    total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_hi got=%h exp=ffffffff", hi); else passed++;
    issue(F_DIVU, 32'd100, 32'd7, s);
    total++; if (s != 33) $display("FAIL divu_stalls got=%0d exp=33", s); else passed++;
    total++; if (lo !== 32'd14) $display("FAIL divu_lo got=%h exp=0000000e", lo); else passed++;
    total++; if (hi !== 32'd2) $display("FAIL divu_hi got=%h exp=00000002", hi); else passed++;
    m_hi = 32'd2; m_lo = 32'd14;
  endtask

  task automatic test_div_edge();
    int s;
    issue(F_DIVU, 32'd5, 32'd0, s);
    total++; if (s != 33) $display("FAIL divz_stalls got=%0d exp=33", s); else passed++;
    total++; if (lo !== 32'hFFFF_FFFF) $display("FAIL divz_lo got=%h exp=ffffffff", lo); else passed++;
    total++; if (hi !== 32'd5) $display("FAIL divz_hi got=%h exp=00000005", hi); else passed++;
    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, s);
    total++; if (lo !== 32'h8000_0000) $display("FAIL divovf_lo got=%h exp=80000000", lo); else passed++;
    total++; if (hi !== 32'd0) $display("FAIL divovf_hi got=%h exp=00000000", hi); else passed++;
    m_hi = 32'd0; m_lo = 32'h8000_0000;
  endtask

  task automatic test_flush();
    int s;
    logic [63:0] e;
    issue(F_MTHI, 32'hAAAA_0001, 32'd0, s);
    issue(F_MTLO, 32'h5555_0002, 32'd0, s);
    m_hi = 32'hAAAA_0001; m_lo = 32'h5555_0002;
    @(negedge clk);
    funct = F_DIV; operand_1 = 32'd1000; operand_2 = 32'd3; op_valid = 1'b1; flush = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    total++; if (stall_req !== 1'b0) $display("FAIL flush_stall got=%b exp=0", stall_req); else passed++;
    idle_cycle();
    total++; if (stall_req !== 1'b0) $display("FAIL flush_idle_stall got=%b exp=0", stall_req); else passed++;
    repeat (30) idle_cycle();
    total++; if (hi !== m_hi) $display("FAIL flush_hi got=%h exp=%h", hi, m_hi); else passed++;
    total++; if (lo !== m_lo) $display("FAIL flush_lo got=%h exp=%h", lo, m_lo); else passed++;
    issue(F_MULT, 32'h1234_5678, 32'hFFFF_FFFB, s);
    e = ref_mul(32'h1234_5678, 32'hFFFF_FFFB, 1'b1);
    total++; if (s != 2) $display("FAIL flush_mult_stalls got=%0d exp=2", s); else passed++;
    total++; if ({hi, lo} !== e) $display("FAIL flush_mult got=%h%h exp=%h", hi, lo, e); else passed++;
    m_hi = e[63:32]; m_lo = e[31:0];
  endtask

  task automatic test_back_to_back();
    int s;
    logic [63:0] e;
    issue(F_MTHI, 32'h0F0F_0F0F, 32'd0, s);
    issue(F_MTLO, 32'hF0F0_F0F0, 32'd0, s);
    @(negedge clk);
    funct = F_DIVU; operand_1 = 32'd12345; operand_2 = 32'd11; op_valid = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    total++; if (hi !== 32'd0) $display("FAIL rstmid_hi got=%h exp=0", hi); else passed++;
    total++; if (lo !== 32'd0) $display("FAIL rstmid_lo got=%h exp=0", lo); else passed++;
    total++; if (stall_req !== 1'b0) $display("FAIL rstmid_stall got=%b exp=0", stall_req); else passed++;
    @(negedge clk);
    op_valid = 1'b0;
    rst = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (40) idle_cycle();
    total++; if ({hi, lo} !== 64'd0) $display("FAIL rstmid_partial got=%h%h exp=0", hi, lo); else passed++;
    issue(F_DIV, 32'hFFFF_FC00, 32'd7, s);
    e = ref_div(32'hFFFF_FC00, 32'd7, 1'b1);
    total++; if (s != 33) $display("FAIL b2b_first_stalls got=%0d exp=33", s); else passed++;
    total++; if ({hi, lo} !== e) $display("FAIL b2b_first got=%h%h exp=%h", hi, lo, e); else passed++;
    issue(F_DIVU, 32'd999_999, 32'd1000, s);
    e = ref_div(32'd999_999, 32'd1000, 1'b0);
    total++; if (s != 33) $display("FAIL b2b_second_stalls got=%0d exp=33", s); else passed++;
    total++; if ({hi, lo} !== e) $display("FAIL b2b_second got=%h%h exp=%h", hi, lo, e); else passed++;
    m_hi = e[63:32]; m_lo = e[31:0];
  endtask

  task automatic test_random();
    logic [5:0]  fl [8];
    logic [5:0]  f;
    logic [31:0] a, b;
    logic [63:0] e;
    int s, exp_s;
    fl = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_MFHI, F_MFLO};
    for (int i = 0; i < 40; i++) begin
      f = fl[$urandom_range(0, 7)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      exp_s = 0;
      e = {m_hi, m_lo};
      case (f)
        F_MULT:  begin e = ref_mul(a, b, 1'b1); exp_s = 2; end
        F_MULTU: begin e = ref_mul(a, b, 1'b0); exp_s = 2; end
        F_DIV:   begin e = ref_div(a, b, 1'b1); exp_s = 33; end
        F_DIVU:  begin e = ref_div(a, b, 1'b0); exp_s = 33; end
        F_MTHI:  e = {a, m_lo};
        F_MTLO:  e = {m_hi, a};
        default: e = {m_hi, m_lo};
      endcase
      issue(f, a, b, s);
      total++;
      if (s != exp_s) $display("FAIL rnd_stalls[%0d] f=%h got=%0d exp=%0d", i, f, s, exp_s);
      else passed++;
      if (f == F_MFHI || f == F_MFLO) begin
        total++;
        if (read_data !== ((f == F_MFHI) ? m_hi : m_lo))
          $display("FAIL rnd_read[%0d] f=%h got=%h exp=%h", i, f, read_data,
                   (f == F_MFHI) ? m_hi : m_lo);
        else passed++;
      end
      idle_cycle();
      m_hi = e[63:32]; m_lo = e[31:0];
      total++;
      if ({hi, lo} !== e) $display("FAIL rnd_hilo[%0d] f=%h a=%h b=%h got=%h%h exp=%h",
                                   i, f, a, b, hi, lo, e);
      else passed++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mt_mf();
    test_mult();
    test_div();
    test_div_edge();
    test_flush();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
